// File: rtl/exe_muldiv.sv
// HI/LO unit: signed MULT done in one cycle, signed DIV done 1 bit/cycle, MFHI/MFLO read port.
// Latency: MULT writes HI/LO at the end of its cycle; DIV stalls DIV_CYCLES+1 cycles (1 for /0). Backpressure: stallreq_exe holds the pipe while a DIV runs.
module exe_muldiv #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic [7:0]  exe_aluop_i,
    input  logic        exe_whilo_i,
    input  logic [31:0] exe_src1_i,
    input  logic [31:0] exe_src2_i,
    output logic [31:0] hilo_rd_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_exe,
    output logic        div_busy_o
);

    localparam logic [7:0] OP_MULT = 8'h14;
    localparam logic [7:0] OP_DIV  = 8'h16;
    localparam logic [7:0] OP_MFHI = 8'h0C;
    localparam logic [7:0] OP_MFLO = 8'h0D;
    localparam int         CW      = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [31:0]   rem_q;
    logic [31:0]   quo_q;
    logic [31:0]   dvs_q;
    logic          qsign_q;
    logic          rsign_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic          start_mul;
    logic          start_div;
    logic [31:0]   abs1;
    logic [31:0]   abs2;
    logic [63:0]   prod;
    logic [32:0]   rem_shift;
    logic          rem_ge;
    logic [31:0]   rem_d;
    logic [31:0]   quo_d;
    logic [31:0]   hi_div;
    logic [31:0]   lo_div;

    assign start_mul = exe_whilo_i && (exe_aluop_i == OP_MULT);
    assign start_div = exe_whilo_i && (exe_aluop_i == OP_DIV);

    assign abs1 = exe_src1_i[31] ? (~exe_src1_i + 32'd1) : exe_src1_i;
    assign abs2 = exe_src2_i[31] ? (~exe_src2_i + 32'd1) : exe_src2_i;
    assign prod = $signed(exe_src1_i) * $signed(exe_src2_i);

    // Restoring step: bring the next dividend bit into the remainder, subtract if it fits.
    // When it fits the true difference is below the divisor, so 32-bit wraparound is exact.
    assign rem_shift = {rem_q, quo_q[31]};
    assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
    assign rem_d     = rem_ge ? (rem_shift[31:0] - dvs_q) : rem_shift[31:0];
    assign quo_d     = {quo_q[30:0], rem_ge};

    assign hi_div = rsign_q ? (~rem_q + 32'd1) : rem_q;
    assign lo_div = qsign_q ? (~quo_q + 32'd1) : quo_q;

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_mul) begin
                        hi_q <= prod[63:32];
                        lo_q <= prod[31:0];
                    end else if (start_div) begin
                        count_q <= '0;
                        if (exe_src2_i == 32'd0) begin
                            // Divide-by-zero result parked in rem/quo so DONE writes it unchanged.
                            rem_q   <= exe_src1_i;
                            quo_q   <= 32'hFFFF_FFFF;
                            dvs_q   <= '0;
                            qsign_q <= 1'b0;
                            rsign_q <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= abs1;
                            dvs_q   <= abs2;
                            qsign_q <= exe_src1_i[31] ^ exe_src2_i[31];
                            rsign_q <= exe_src1_i[31];
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST_ITER) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The DIV is still on the inputs here; it retires on this edge, no restart.
                    hi_q    <= hi_div;
                    lo_q    <= lo_div;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        hilo_rd_o = 32'd0;
        if (exe_aluop_i == OP_MFHI) begin
            hilo_rd_o = hi_q;
        end else if (exe_aluop_i == OP_MFLO) begin
            hilo_rd_o = lo_q;
        end
    end

    assign stallreq_exe = ((state_q == IDLE) && start_div) || (state_q == BUSY);
    assign div_busy_o   = (state_q == BUSY);
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;

endmodule
